// File: rtl/bank_pkg.sv
// Bank-level constants shared by the linefill controller and the issue queue.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bank_pkg;

  // Cacheline index width (set/way). This is also the BIU read ID width
  // and the issue-queue rid width.
  localparam int BANK_IDX_W         = 6;
  // Pending-miss FIFO depth is 2**LF_FIFO_PTR_W.
  localparam int LF_FIFO_PTR_W      = 3;
  // AR requests allowed in flight before an R-last comes back.
  localparam int LF_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/bank_lf_fifo.sv
// Generic synchronous FIFO holding pending linefill indices.
// Latency: a push is visible on head the cycle after it is written; pop takes effect at the edge.
// Backpressure: a push while full and a pop while empty are dropped; the caller gates both.
//
// Ports: clk, rst_n (async active-low), push/din, pop, head (oldest entry),
//        full, empty.
module bank_lf_fifo #(
  parameter int WIDTH = 6,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the start-of-cycle count, so a push into a full
  // FIFO is refused even when a pop happens in the same cycle.
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bank_linefill_ctrl.sv
// Per-bank linefill scheduler: in-flight bitmap, miss merge, pending FIFO, AR issue, wake-up pulse.
// Latency: AR one cycle after a new miss is accepted; wake-up pulse one cycle after R-last.
// Backpressure: alloc_ready_o drops when the FIFO is full or alloc collides with a completing fill; AR is held until ready.
//
// Ports: alloc_* (miss from issue queue), lookup_* (in-flight query),
//        biu_ar_* / biu_r_* (BIU read channel), isu_rvalid_o/isu_rid_o
//        (wake-up), outstanding_o (AR count), err_o (sticky unmatched R-last).
module bank_linefill_ctrl import bank_pkg::*; #(
  parameter int IDX_W           = BANK_IDX_W,
  parameter int FIFO_PTR_W      = LF_FIFO_PTR_W,
  parameter int MAX_OUTSTANDING = LF_MAX_OUTSTANDING
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             lookup_inflight_o,
  output logic             biu_ar_valid_o,
  input  logic             biu_ar_ready_i,
  output logic [IDX_W-1:0] biu_ar_id_o,
  input  logic             biu_r_valid_i,
  input  logic [IDX_W-1:0] biu_r_id_i,
  input  logic             biu_r_last_i,
  output logic             isu_rvalid_o,
  output logic [IDX_W-1:0] isu_rid_o,
  output logic [IDX_W:0]   outstanding_o,
  output logic             err_o
);

  localparam int             NUM_IDX = 1 << IDX_W;
  localparam logic [IDX_W:0] MAX_OUT = (IDX_W+1)'(MAX_OUTSTANDING);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  logic [NUM_IDX-1:0] inflight_q;
  logic [IDX_W:0]     outstanding_q;
  logic               rvalid_q;
  logic [IDX_W-1:0]   rid_q;
  logic               err_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;

  logic r_done;
  logic r_match;
  logic r_unmatched;
  logic alloc_fire;
  logic alloc_new;
  logic ar_fire;
  logic dec;

  assign r_done      = biu_r_valid_i & biu_r_last_i;
  assign r_match     = r_done & inflight_q[biu_r_id_i];
  assign r_unmatched = r_done & ~inflight_q[biu_r_id_i];

  // Stalling an alloc that hits the index being completed this cycle keeps
  // set and clear of the same bitmap bit from ever landing on one edge.
  assign alloc_ready_o = ~fifo_full & ~(r_done & (biu_r_id_i == alloc_idx_i));
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  // A miss on an index already in flight merges into the existing fill.
  assign alloc_new     = alloc_fire & ~inflight_q[alloc_idx_i];

  // Valid cannot drop without ar_ready: the head only moves on a pop and
  // the outstanding count can only fall while nothing is issued.
  assign biu_ar_valid_o = ~fifo_empty & (outstanding_q < MAX_OUT);
  assign biu_ar_id_o    = fifo_head;
  assign ar_fire        = biu_ar_valid_o & biu_ar_ready_i;

  // Guard against a protocol-violating R-last that would underflow.
  assign dec = r_match & (outstanding_q != '0);

  assign lookup_inflight_o = inflight_q[lookup_idx_i];
  assign outstanding_o     = outstanding_q;
  assign isu_rvalid_o      = rvalid_q;
  assign isu_rid_o         = rid_q;
  assign err_o             = err_q;

  bank_lf_fifo #(
    .WIDTH (IDX_W),
    .PTR_W (FIFO_PTR_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (alloc_new),
    .din   (alloc_idx_i),
    .pop   (ar_fire),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight_q    <= '0;
      outstanding_q <= '0;
      rvalid_q      <= 1'b0;
      rid_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      if (alloc_new) inflight_q[alloc_idx_i] <= 1'b1;
      if (r_match)   inflight_q[biu_r_id_i]  <= 1'b0;

      case ({ar_fire, dec})
        2'b10:   outstanding_q <= outstanding_q + ONE;
        2'b01:   outstanding_q <= outstanding_q - ONE;
        default: outstanding_q <= outstanding_q;
      endcase

      rvalid_q <= r_match;
      if (r_match) rid_q <= biu_r_id_i;

      if (r_unmatched) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_linefill_ctrl.sv
// Directed self-checking bench for bank_linefill_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_bank_linefill_ctrl;

  logic       clk;
  logic       rst_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [5:0] alloc_idx;
  logic [5:0] lookup_idx;
  logic       lookup_inflight;
  logic       ar_valid;
  logic       ar_ready;
  logic [5:0] ar_id;
  logic       r_valid;
  logic [5:0] r_id;
  logic       r_last;
  logic       isu_rvalid;
  logic [5:0] isu_rid;
  logic [6:0] outstanding;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;
  int ar_cnt = 0;
  int pulse_cnt = 0;
  int a0;
  int p0;

  bank_linefill_ctrl dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .alloc_valid_i     (alloc_valid),
    .alloc_ready_o     (alloc_ready),
    .alloc_idx_i       (alloc_idx),
    .lookup_idx_i      (lookup_idx),
    .lookup_inflight_o (lookup_inflight),
    .biu_ar_valid_o    (ar_valid),
    .biu_ar_ready_i    (ar_ready),
    .biu_ar_id_o       (ar_id),
    .biu_r_valid_i     (r_valid),
    .biu_r_id_i        (r_id),
    .biu_r_last_i      (r_last),
    .isu_rvalid_o      (isu_rvalid),
    .isu_rid_o         (isu_rid),
    .outstanding_o     (outstanding),
    .err_o             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are stable from posedge+1 to the next posedge, so the negedge
  // sees the handshake values of the current cycle.
  always @(negedge clk) begin
    if (rst_n && ar_valid && ar_ready) ar_cnt <= ar_cnt + 1;
    if (isu_rvalid) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    r_valid     = 1'b0;
    r_last      = 1'b0;
  endtask

  task automatic rlast(input logic [5:0] id);
    r_valid = 1'b1;
    r_last  = 1'b1;
    r_id    = id;
  endtask

  task automatic reset_dut();
    idle();
    ar_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [5:0] drain [5];
    drain = '{6'h20, 6'h22, 6'h23, 6'h24, 6'h25};
    rst_n = 1'b0;
    alloc_valid = 1'b0; alloc_idx = '0; lookup_idx = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_id = '0; r_last = 1'b0;
    tick(); tick();
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_isu_rvalid", isu_rvalid, 0);
    chk("rst_isu_rid", isu_rid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single miss 0x15.
    ar_ready = 1'b1; lookup_idx = 6'h15;
    alloc_valid = 1'b1; alloc_idx = 6'h15;
    #1;
    chk("t1_alloc_ready", alloc_ready, 1);
    chk("t1_lookup_before", lookup_inflight, 0);
    tick();
    idle();
    #1;
    chk("t1_ar_valid", ar_valid, 1);
    chk("t1_ar_id", ar_id, 6'h15);
    chk("t1_lookup_inflight", lookup_inflight, 1);
    chk("t1_out0", outstanding, 0);
    tick();
    chk("t1_out1", outstanding, 1);
    chk("t1_ar_valid_after", ar_valid, 0);
    r_valid = 1'b1; r_id = 6'h15; r_last = 1'b0;
    tick();
    chk("t1_nonlast_no_pulse", isu_rvalid, 0);
    chk("t1_nonlast_inflight", lookup_inflight, 1);
    rlast(6'h15);
    tick();
    idle();
    #1;
    chk("t1_pulse", isu_rvalid, 1);
    chk("t1_pulse_rid", isu_rid, 6'h15);
    chk("t1_out_back0", outstanding, 0);
    chk("t1_lookup_after", lookup_inflight, 0);
    tick();
    chk("t1_pulse_single", isu_rvalid, 0);
    chk("t1_rid_hold", isu_rid, 6'h15);

    // Duplicate miss 0x07.
    a0 = ar_cnt; p0 = pulse_cnt;
    ar_ready = 1'b0;
    alloc_valid = 1'b1; alloc_idx = 6'h07;
    tick();
    #1;
    chk("t2_merge_ready", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0; ar_ready = 1'b1;
    #1;
    chk("t2_ar_valid", ar_valid, 1);
    chk("t2_ar_id", ar_id, 6'h07);
    tick();
    alloc_valid = 1'b1; alloc_idx = 6'h07;
    #1;
    chk("t2_merge_inflight_ready", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("t2_single_entry", ar_valid, 0);
    rlast(6'h07);
    tick();
    idle();
    tick(); tick();
    chk("t2_one_ar", ar_cnt - a0, 1);
    chk("t2_one_pulse", pulse_cnt - p0, 1);
    chk("t2_out0", outstanding, 0);

    // Outstanding limit with six misses.
    a0 = ar_cnt; p0 = pulse_cnt;
    ar_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1; alloc_idx = 6'(6'h20 + i);
      tick();
    end
    alloc_valid = 1'b0;
    tick(); tick();
    chk("t3_out_max", outstanding, 4);
    chk("t3_ar_blocked", ar_valid, 0);
    chk("t3_four_ar", ar_cnt - a0, 4);
    rlast(6'h21);
    tick();
    idle();
    #1;
    chk("t3_fifth_ar_valid", ar_valid, 1);
    chk("t3_fifth_ar_id", ar_id, 6'h24);
    chk("t3_pulse_rid", isu_rid, 6'h21);
    chk("t3_out3", outstanding, 3);
    tick();
    chk("t3_out_max_again", outstanding, 4);
    chk("t3_sixth_blocked", ar_valid, 0);
    for (int i = 0; i < 5; i++) begin
      rlast(drain[i]);
      tick();
    end
    idle();
    tick();
    chk("t3_drained", outstanding, 0);
    chk("t3_six_ar", ar_cnt - a0, 6);
    chk("t3_six_pulse", pulse_cnt - p0, 6);

    // FIFO full.
    ar_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_idx = 6'(6'h30 + i);
      #1;
      chk("t4_fill_ready", alloc_ready, 1);
      tick();
    end
    alloc_idx = 6'h38;
    #1;
    chk("t4_full_ready", alloc_ready, 0);
    chk("t4_head_valid", ar_valid, 1);
    chk("t4_head_id", ar_id, 6'h30);
    tick();
    ar_ready = 1'b1;
    #1;
    chk("t4_full_while_pop", alloc_ready, 0);
    tick();
    ar_ready = 1'b0;
    #1;
    chk("t4_ready_returns", alloc_ready, 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("t4_refull", alloc_ready, 0);
    chk("t4_next_head", ar_id, 6'h31);
    reset_dut();
    lookup_idx = 6'h30;
    #1;
    chk("t4_reset_bitmap", lookup_inflight, 0);
    chk("t4_reset_ready", alloc_ready, 1);
    chk("t4_reset_out", outstanding, 0);

    // Collision between alloc and completing fill.
    a0 = ar_cnt;
    ar_ready = 1'b1; lookup_idx = 6'h3A;
    alloc_valid = 1'b1; alloc_idx = 6'h3A;
    tick();
    alloc_valid = 1'b0;
    tick();
    chk("t5_issued", ar_cnt - a0, 1);
    alloc_valid = 1'b1; alloc_idx = 6'h3A;
    rlast(6'h3A);
    alloc_valid = 1'b1;
    #1;
    chk("t5_collide_ready", alloc_ready, 0);
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    #1;
    chk("t5_ready_next", alloc_ready, 1);
    chk("t5_bit_cleared", lookup_inflight, 0);
    chk("t5_pulse", isu_rvalid, 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("t5_new_ar_valid", ar_valid, 1);
    chk("t5_new_ar_id", ar_id, 6'h3A);
    tick();
    chk("t5_two_ar", ar_cnt - a0, 2);
    rlast(6'h3A);
    tick();
    idle();
    tick();
    chk("t5_out0", outstanding, 0);

    // Unmatched R-last.
    p0 = pulse_cnt;
    rlast(6'h01);
    tick();
    idle();
    #1;
    chk("t6_err", err, 1);
    chk("t6_no_pulse", isu_rvalid, 0);
    chk("t6_out0", outstanding, 0);
    tick();
    chk("t6_err_sticky", err, 1);
    chk("t6_no_pulse_cnt", pulse_cnt - p0, 0);

    // Async reset with two fills outstanding.
    ar_ready = 1'b1;
    alloc_valid = 1'b1; alloc_idx = 6'h10;
    tick();
    alloc_idx = 6'h11;
    tick();
    alloc_valid = 1'b0;
    tick();
    chk("t7_out2", outstanding, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_ar_valid", ar_valid, 0);
    chk("t7_rst_out", outstanding, 0);
    chk("t7_rst_isu_rvalid", isu_rvalid, 0);
    chk("t7_rst_isu_rid", isu_rid, 0);
    chk("t7_rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    p0 = pulse_cnt;
    rlast(6'h10);
    tick();
    idle();
    #1;
    chk("t7_late_err", err, 1);
    chk("t7_late_no_pulse", isu_rvalid, 0);
    chk("t7_late_out", outstanding, 0);
    tick();
    chk("t7_late_pulse_cnt", pulse_cnt - p0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
